// File: rtl/uvmt_axis_st_pkt_sink_if.sv
// AXI-Stream handshake/data bundle between a stream master and the packet sink.
interface uvmt_axis_st_pkt_sink_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/uvmt_axis_st_pkt_sink.sv
// AXI-Stream receive end: programmable back-pressure, incrementing-data and
// packet-length checking, beat/packet/error counters for scoreboard cross-check.
module uvmt_axis_st_pkt_sink #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PKT_LEN = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    uvmt_axis_st_pkt_sink_if.slave   axis,
    input  logic                     cfg_en_i,
    input  logic [1:0]               cfg_ready_mode_i,
    input  logic [15:0]              cfg_seed_i,
    input  logic [7:0]               cfg_gap_i,
    output logic [31:0]              beat_cnt_o,
    output logic [31:0]              pkt_cnt_o,
    output logic                     data_err_o,
    output logic                     len_err_o,
    output logic [15:0]              err_cnt_o,
    output logic                     busy_o
);
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned ERR_SUM_W = ERR_W + 1;
    localparam int unsigned GAP_W     = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEF  = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    state_e              state_q,    state_d;
    logic                tready_q,   tready_d;
    logic [LFSR_W-1:0]   lfsr_q,     lfsr_d;
    logic [DATA_W-1:0]   exp_q,      exp_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic [GAP_W-1:0]    gap_q,      gap_d;
    logic [CNT_W-1:0]    beat_q,     beat_d;
    logic [CNT_W-1:0]    pkt_q,      pkt_d;
    logic                data_err_q, data_err_d;
    logic                len_err_q,  len_err_d;
    logic [ERR_W-1:0]    err_q,      err_d;
    logic                busy_q,     busy_d;

    logic                 accept_c;
    logic                 data_mis_c;
    logic                 len_over_c;
    logic                 gap_en_c;
    logic [ERR_SUM_W-1:0] err_sum_c;

    assign accept_c   = axis.tvalid && tready_q;
    assign data_mis_c = accept_c && (axis.tdata != exp_q);
    // The beat being accepted is number len_q+1 of its packet.
    assign len_over_c = accept_c && (len_q >= LEN_W'(MAX_PKT_LEN));
    assign gap_en_c   = (cfg_gap_i != '0) &&
                        ((cfg_ready_mode_i == 2'd1) || (cfg_ready_mode_i == 2'd2));
    assign err_sum_c  = {1'b0, err_q} + ERR_SUM_W'(data_mis_c) + ERR_SUM_W'(len_over_c);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tready_q   <= 1'b0;
            lfsr_q     <= (cfg_seed_i == '0) ? LFSR_DEF : cfg_seed_i;
            exp_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            beat_q     <= '0;
            pkt_q      <= '0;
            data_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            lfsr_q     <= lfsr_d;
            exp_q      <= exp_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            data_err_q <= data_err_d;
            len_err_q  <= len_err_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        len_d      = len_q;
        gap_d      = gap_q;
        beat_d     = beat_q;
        pkt_d      = pkt_q;
        data_err_d = data_err_q | data_mis_c;
        len_err_d  = len_err_q | len_over_c;
        err_d      = err_sum_c[ERR_W] ? {ERR_W{1'b1}} : err_sum_c[ERR_W-1:0];
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

        // Checker resynchronises on the received value, not the expected one.
        if (accept_c) begin
            beat_d = beat_q + CNT_W'(1);
            exp_d  = axis.tdata + DATA_W'(1);
            if (axis.tlast) begin
                pkt_d = pkt_q + CNT_W'(1);
                len_d = '0;
            end else if (len_q != {LEN_W{1'b1}}) begin
                len_d = len_q + LEN_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_IN_PKT: begin
                if (accept_c) begin
                    if (!axis.tlast) begin
                        state_d = ST_IN_PKT;
                    end else if (gap_en_c) begin
                        state_d = ST_GAP;
                        gap_d   = cfg_gap_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready looks at the post-edge state so a gap starts right after tlast.
        if (!cfg_en_i || (state_d == ST_GAP)) begin
            tready_d = 1'b0;
        end else if (cfg_ready_mode_i == 2'd1) begin
            tready_d = lfsr_q[0];
        end else begin
            tready_d = 1'b1;
        end

        busy_d = (state_d == ST_IN_PKT);
    end

    assign axis.tready = tready_q;
    assign beat_cnt_o  = beat_q;
    assign pkt_cnt_o   = pkt_q;
    assign data_err_o  = data_err_q;
    assign len_err_o   = len_err_q;
    assign err_cnt_o   = err_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_uvmt_axis_st_pkt_sink.sv
// Scoreboard bench for uvmt_axis_st_pkt_sink: directed beats push expected
// counter/flag snapshots; a monitor pops and compares after every accepted beat.
module tb_uvmt_axis_st_pkt_sink;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MAX_PKT_LEN = 4;

    typedef struct packed {
        logic [31:0] beat;
        logic [31:0] pkt;
        logic        derr;
        logic        lerr;
        logic [15:0] ecnt;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_en;
    logic [1:0]  cfg_ready_mode;
    logic [15:0] cfg_seed;
    logic [7:0]  cfg_gap;
    logic [31:0] beat_cnt;
    logic [31:0] pkt_cnt;
    logic        data_err;
    logic        len_err;
    logic [15:0] err_cnt;
    logic        busy;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   lfsr_done;

    uvmt_axis_st_pkt_sink_if #(.DATA_W(DATA_W)) axis_if ();

    uvmt_axis_st_pkt_sink #(
        .DATA_W      (DATA_W),
        .MAX_PKT_LEN (MAX_PKT_LEN)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .axis             (axis_if),
        .cfg_en_i         (cfg_en),
        .cfg_ready_mode_i (cfg_ready_mode),
        .cfg_seed_i       (cfg_seed),
        .cfg_gap_i        (cfg_gap),
        .beat_cnt_o       (beat_cnt),
        .pkt_cnt_o        (pkt_cnt),
        .data_err_o       (data_err),
        .len_err_o        (len_err),
        .err_cnt_o        (err_cnt),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int b, input int p, input bit de, input bit le,
                                input int ec, input bit bz);
        exp_t e;
        e.beat = 32'(b);
        e.pkt  = 32'(p);
        e.derr = de;
        e.lerr = le;
        e.ecnt = 16'(ec);
        e.busy = bz;
        return e;
    endfunction

    function automatic exp_t cur();
        exp_t e;
        e = {beat_cnt, pkt_cnt, data_err, len_err, err_cnt, busy};
        return e;
    endfunction

    // Monitor: an accept on a rising edge is checked on the following falling edge.
    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = reset_n && axis_if.tvalid && axis_if.tready;
            @(negedge clk);
            if (acc) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: beat_cnt 0x%0h accepted with no expectation queued", beat_cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_snapshot", 96'(cur()), 96'(e));
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input exp_t e, output int waited);
        waited = 0;
        sb_q.push_back(e);
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = d;
        axis_if.tlast  = l;
        do begin
            @(posedge clk);
            waited++;
        end while (!axis_if.tready && waited < 100);
        if (!axis_if.tready) begin
            n_cmp++;
            n_bad++;
            void'(sb_q.pop_back());
            $display("FAIL send_timeout: data 0x%0h not accepted, waited %0d want <100", d, waited);
        end
        @(negedge clk);
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [7:0] gap,
                            input logic [15:0] seed, input logic en);
        @(negedge clk);
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        reset_n        = 1'b0;
        cfg_ready_mode = mode;
        cfg_gap        = gap;
        cfg_seed       = seed;
        cfg_en         = en;
        repeat (2) @(negedge clk);
        chk("sb_drained", 96'(sb_q.size()), 96'(0));
        chk("reset_state", 96'({axis_if.tready, cur()}), 96'({1'b0, mk(0, 0, 0, 0, 0, 0)}));
        reset_n = 1'b1;
    endtask

    initial begin
        int w;
        int tot;
        int n;
        int k;
        logic [15:0] m;

        reset_n        = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tdata  = '0;
        axis_if.tlast  = 1'b0;
        cfg_en         = 1'b0;
        cfg_ready_mode = 2'd0;
        cfg_seed       = 16'h0;
        cfg_gap        = 8'd0;

        // Mode 0: three back-to-back 4-beat packets, data 0..11.
        do_reset(2'd0, 8'd0, 16'h1234, 1'b1);
        @(negedge clk);
        chk("t1_tready_first_cycle", 96'(axis_if.tready), 96'(1));
        tot = 0;
        for (int i = 0; i < 12; i++) begin
            send(32'(i), (i % 4) == 3, mk(i + 1, (i + 1) / 4, 0, 0, 0, (i % 4) != 3), w);
            tot += w;
        end
        chk("t1_back_to_back_cycles", 96'(tot), 96'(12));

        // Mode 2, gap 5: two 2-beat packets, master always valid.
        do_reset(2'd2, 8'd5, 16'h1234, 1'b1);
        send(32'd0, 1'b0, mk(1, 0, 0, 0, 0, 1), w);
        send(32'd1, 1'b1, mk(2, 1, 0, 0, 0, 0), w);
        send(32'd2, 1'b0, mk(3, 1, 0, 0, 0, 1), w);
        chk("t2_wait_after_gap", 96'(w), 96'(6));
        send(32'd3, 1'b1, mk(4, 2, 0, 0, 0, 0), w);
        n = 0;
        while (!axis_if.tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_gap_low_cycles", 96'(n), 96'(5));

        // Data mismatch at third beat, resync afterwards.
        do_reset(2'd0, 8'd0, 16'h1234, 1'b1);
        send(32'd0, 1'b0, mk(1, 0, 0, 0, 0, 1), w);
        send(32'd1, 1'b0, mk(2, 0, 0, 0, 0, 1), w);
        send(32'd7, 1'b0, mk(3, 0, 1, 0, 1, 1), w);
        send(32'd8, 1'b1, mk(4, 1, 1, 0, 1, 0), w);

        // 6-beat packet with MAX_PKT_LEN = 4: beats 5 and 6 are over-length.
        do_reset(2'd0, 8'd0, 16'h1234, 1'b1);
        send(32'd0, 1'b0, mk(1, 0, 0, 0, 0, 1), w);
        send(32'd1, 1'b0, mk(2, 0, 0, 0, 0, 1), w);
        send(32'd2, 1'b0, mk(3, 0, 0, 0, 0, 1), w);
        send(32'd3, 1'b0, mk(4, 0, 0, 0, 0, 1), w);
        send(32'd4, 1'b0, mk(5, 0, 0, 1, 1, 1), w);
        send(32'd5, 1'b1, mk(6, 1, 0, 1, 2, 0), w);

        // Mode 1, seed 0: LFSR reference runs from 0xACE1.
        do_reset(2'd1, 8'd0, 16'h0000, 1'b1);
        lfsr_done = 1'b0;
        k = 0;
        fork
            begin
                m = 16'hACE1;
                for (int c = 0; c < 64; c++) begin
                    @(negedge clk);
                    chk($sformatf("t5_lfsr_tready_c%0d", c), 96'(axis_if.tready), 96'(m[0]));
                    m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
                end
                lfsr_done = 1'b1;
            end
            begin
                while (!lfsr_done) begin
                    send(32'(k), 1'b1, mk(k + 1, k + 1, 0, 0, 0, 0), w);
                    k++;
                end
            end
        join
        @(negedge clk);
        chk("t5_beats_vs_sent", 96'(beat_cnt), 96'(k));

        // Reset mid-packet after 3 beats, then a single-beat packet.
        do_reset(2'd0, 8'd0, 16'h1234, 1'b1);
        send(32'd0, 1'b0, mk(1, 0, 0, 0, 0, 1), w);
        send(32'd1, 1'b0, mk(2, 0, 0, 0, 0, 1), w);
        send(32'd2, 1'b0, mk(3, 0, 0, 0, 0, 1), w);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("t6_en_off_ready_busy", 96'({axis_if.tready, busy}), 96'(2'b01));
        do_reset(2'd0, 8'd0, 16'h1234, 1'b1);
        send(32'd0, 1'b1, mk(1, 1, 0, 0, 0, 0), w);

        repeat (3) @(negedge clk);
        chk("sb_empty_at_end", 96'(sb_q.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
